// File: rtl/cpu_defs.sv
// Shared CPU definitions: access-source encoding used by the memory port arbiter.
package cpu_defs;

  typedef logic [1:0] mem_src_t;

  localparam mem_src_t SRC_NONE = 2'b00;
  localparam mem_src_t SRC_IF   = 2'b01;
  localparam mem_src_t SRC_DM   = 2'b10;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM between fetch and data ports; grant in cycle N, ack/data in N+1.
// No backpressure beyond the grant: a losing requester holds its request, MEM wins unless IF is starved.
module mem_port_arbiter
  import cpu_defs::*;
#(
  parameter int AW         = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cancel,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic [3:0]    dm_wen,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_ack,
  output logic [31:0]   dm_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic [31:0]   conflict_cnt
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  mem_src_t    pend_src;
  mem_src_t    grant;
  logic [2:0]  starve_cnt;
  logic [31:0] conflict_q;
  logic        if_el;
  logic        dm_el;

  // The source acked this cycle is masked so its still-held request is not regranted.
  always_comb begin
    if_el = resetn & if_req & ~cancel & (pend_src != SRC_IF);
    dm_el = resetn & dm_req & (pend_src != SRC_DM);
    if (dm_el && if_el && (starve_cnt == STARVE_LIM))
      grant = SRC_IF;
    else if (dm_el)
      grant = SRC_DM;
    else if (if_el)
      grant = SRC_IF;
    else
      grant = SRC_NONE;
  end

  always_comb begin
    ram_en    = (grant != SRC_NONE);
    ram_wen   = 4'h0;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    if (grant == SRC_DM) begin
      ram_wen   = dm_wen;
      ram_addr  = dm_addr[AW+1:2];
      ram_wdata = dm_wdata;
    end else if (grant == SRC_IF) begin
      ram_addr  = if_addr[AW+1:2];
    end
  end

  assign dm_ack       = resetn & (pend_src == SRC_DM);
  assign if_ack       = resetn & (pend_src == SRC_IF) & ~cancel;
  assign if_rdata     = ram_rdata;
  assign dm_rdata     = ram_rdata;
  assign conflict_cnt = resetn ? conflict_q : 32'h0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_src   <= SRC_NONE;
      starve_cnt <= 3'd0;
      conflict_q <= 32'h0;
    end else begin
      pend_src <= grant;
      if (if_el && (grant == SRC_DM)) begin
        if (starve_cnt != STARVE_LIM)
          starve_cnt <= starve_cnt + 3'd1;
      end else if ((grant == SRC_IF) || !if_req || cancel) begin
        starve_cnt <= 3'd0;
      end
      if (if_el && dm_el)
        conflict_q <= conflict_q + 32'd1;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0], dm_addr[31:AW+2], dm_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a cycle-level reference model.
module tb_mem_port_arbiter;

  localparam int AW         = 8;
  localparam int STARVE_MAX = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cancel;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_ack;
  logic [31:0]   if_rdata;
  logic          dm_req;
  logic [3:0]    dm_wen;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_ack;
  logic [31:0]   dm_rdata;
  logic          ram_en;
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [31:0]   conflict_cnt;

  mem_port_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .resetn(resetn), .cancel(cancel),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(int i);
    if (i == 4) return 32'h2402000A;
    return 32'hA5000000 ^ (i * 32'h00010203);
  endfunction

  // Environment RAM: synchronous read, byte-enable write.
  logic [31:0] ram [0:(1<<AW)-1];
  logic [31:0] ram_w;
  initial for (int i = 0; i < (1<<AW); i++) ram[i] <= init_val(i);
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram[ram_addr];
      ram_w = ram[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) ram_w[8*b +: 8] = ram_wdata[8*b +: 8];
      ram[ram_addr] <= ram_w;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory image, last-granted source, starvation and conflict counts.
  typedef struct {
    int          due;
    int          src;   // 1 = fetch, 2 = data
    bit          is_wr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          m_last = 0;
  int          m_starve = 0;
  logic [31:0] m_conflict = 0;

  initial for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_val(i);

  always @(negedge clk) begin
    int g;
    bit ie, de;
    int wi, wd;
    exp_t e;
    g = 0; ie = 0; de = 0;
    wi = int'(if_addr[AW+1:2]);
    wd = int'(dm_addr[AW+1:2]);
    if (!resetn) begin
      m_last = 0; m_starve = 0; m_conflict = 0;
    end else begin
      ie = if_req && !cancel && (m_last != 1);
      de = dm_req && (m_last != 2);
      if (de && ie && m_starve >= STARVE_MAX) g = 1;
      else if (de) g = 2;
      else if (ie) g = 1;
    end

    chk("ram_en", 32'(ram_en), 32'(g != 0));
    chk("ram_wen", 32'(ram_wen), (g == 2) ? 32'(dm_wen) : 32'h0);
    chk("conflict_cnt", conflict_cnt, m_conflict);
    if (!resetn) begin
      chk("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("rst_ram_wdata", ram_wdata, 32'h0);
    end
    if (g == 1) chk("ram_addr_if", 32'(ram_addr), 32'(wi));
    if (g == 2) begin
      chk("ram_addr_dm", 32'(ram_addr), 32'(wd));
      if (dm_wen != 4'h0) chk("ram_wdata", ram_wdata, dm_wdata);
    end

    if (g != 0) begin
      e.due   = cyc + 1;
      e.src   = g;
      e.is_wr = (g == 2) && (dm_wen != 4'h0);
      e.data  = (g == 1) ? ref_mem[wi] : ref_mem[wd];
      sb.push_back(e);
      if (e.is_wr)
        for (int b = 0; b < 4; b++)
          if (dm_wen[b]) ref_mem[wd][8*b +: 8] = dm_wdata[8*b +: 8];
    end

    if (resetn) begin
      if (ie && g == 2) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      else if (g == 1 || !if_req || cancel) m_starve = 0;
      if (ie && de) m_conflict = m_conflict + 32'd1;
      m_last = g;
    end
  end

  // Monitor: pops the access due this cycle and checks acks and returned data.
  always @(negedge clk) begin
    exp_t e;
    bit have, exp_if, exp_dm;
    have = 0;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      chk("stale_entry", 32'(e.due), 32'(cyc));
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      have = 1;
    end
    exp_if = have && resetn && (e.src == 1) && !cancel;
    exp_dm = have && resetn && (e.src == 2);
    chk("if_ack", 32'(if_ack), 32'(exp_if));
    chk("dm_ack", 32'(dm_ack), 32'(exp_dm));
    if (exp_if && if_ack) chk("if_rdata", if_rdata, e.data);
    if (exp_dm && dm_ack && !e.is_wr) chk("dm_rdata", dm_rdata, e.data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    r[AW+1:2] = AW'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    bit saw_if, saw_dm, c_prev;
    resetn = 0; cancel = 0;
    if_req = 0; if_addr = 0;
    dm_req = 0; dm_wen = 0; dm_addr = 0; dm_wdata = 0;
    repeat (3) step();
    resetn = 1;

    // Fetch only from byte 0x10 (word 4) for three cycles.
    if_req = 1; if_addr = 32'h10;
    repeat (3) step();
    if_req = 0;
    step();

    // Store then load at 0x20.
    dm_req = 1; dm_wen = 4'hF; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
    step();
    dm_req = 0; dm_wen = 4'h0;
    step();
    dm_req = 1; dm_addr = 32'h20;
    step();
    dm_req = 0;
    step();

    // Both requesters held continuously.
    if_req = 1; if_addr = 32'h40;
    dm_req = 1; dm_addr = 32'h44; dm_wen = 4'h0;
    repeat (8) step();
    if_req = 0; dm_req = 0;
    repeat (2) step();

    // Fetch granted, then cancel in its ack cycle alongside a data read.
    if_req = 1; if_addr = 32'h08;
    step();
    cancel = 1; dm_req = 1; dm_addr = 32'h20;
    step();
    cancel = 0; if_req = 0; dm_req = 0;
    repeat (2) step();

    // Reset asserted in the ack cycle of a data read.
    dm_req = 1; dm_addr = 32'h20;
    step();
    resetn = 0; dm_req = 0;
    repeat (2) step();
    resetn = 1;
    repeat (3) step();

    // Randomized traffic honouring the request-hold protocol.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      saw_if = if_ack; saw_dm = dm_ack; c_prev = cancel;
      @(posedge clk);
      #1;
      if (dm_req && saw_dm) dm_req = 0;
      if (!dm_req && $urandom_range(0, 99) < 60) begin
        dm_req   = 1;
        dm_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        dm_addr  = rand_addr();
        dm_wdata = $urandom;
      end
      if (if_req && (saw_if || c_prev)) if_req = 0;
      if (!if_req && $urandom_range(0, 99) < 70) begin
        if_req  = 1;
        if_addr = rand_addr();
      end
      cancel = ($urandom_range(0, 99) < 8);
      if (!resetn) resetn = 1;
      else if ($urandom_range(0, 299) == 0) begin
        resetn = 0; if_req = 0; dm_req = 0;
      end
    end

    resetn = 1; if_req = 0; dm_req = 0; cancel = 0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
